// File: rtl/lsb_queue_v2_pkg.sv
// Shared types for the in-order load/store buffer: op-type field encoding,
// request FSM states, queue entry layout and the load extension helper.
package lsb_pkg;

   localparam int LSB_XLEN  = 32;
   localparam int LSB_ROB_W = 4;

   localparam int STORE_BIT    = 3;
   localparam int UNSIGNED_BIT = 2;
   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;

   typedef enum logic {
      IDLE,
      REQ
   } lsb_state_e;

   typedef struct packed {
      logic                 valid;
      logic                 committed;
      logic                 killed;
      logic [3:0]           op_type;
      logic [LSB_XLEN-1:0]  data_j;
      logic [LSB_XLEN-1:0]  data_k;
      logic                 pending_j;
      logic                 pending_k;
      logic [LSB_ROB_W-1:0] dep_j;
      logic [LSB_ROB_W-1:0] dep_k;
      logic [LSB_ROB_W-1:0] rob_id;
      logic [LSB_XLEN-1:0]  imm;
   } lsb_entry_t;

   // Memory control returns raw data in the low bytes; widen per size/sign.
   function automatic logic [LSB_XLEN-1:0] extend_load(input logic [3:0] op_type,
                                                       input logic [LSB_XLEN-1:0] raw);
      logic sx;
      logic [LSB_XLEN-1:0] res;
      case (op_type[1:0])
         SIZE_B: begin
            sx  = !op_type[UNSIGNED_BIT] && raw[7];
            res = {{(LSB_XLEN-8){sx}}, raw[7:0]};
         end
         SIZE_H: begin
            sx  = !op_type[UNSIGNED_BIT] && raw[15];
            res = {{(LSB_XLEN-16){sx}}, raw[15:0]};
         end
         default: begin
            sx  = 1'b0;
            res = raw;
         end
      endcase
      return res;
   endfunction

endpackage

// File: rtl/lsb_queue_v2_bc_match.sv
// Snoops all broadcast channels for one operand tag; the lowest matching
// channel index supplies the data.
module lsb_bc_match #(
   parameter int NUM_BC = 2,
   parameter int ROB_W  = 4,
   parameter int XLEN   = 32
) (
   input  logic [ROB_W-1:0]        tag,
   input  logic [NUM_BC-1:0]       bc_en,
   input  logic [NUM_BC*ROB_W-1:0] bc_rob_id,
   input  logic [NUM_BC*XLEN-1:0]  bc_data,
   output logic                    hit,
   output logic [XLEN-1:0]         data
);

   always_comb begin
      hit  = 1'b0;
      data = '0;
      for (int c = NUM_BC - 1; c >= 0; c--) begin
         if (bc_en[c] && (bc_rob_id[c*ROB_W +: ROB_W] == tag)) begin
            hit  = 1'b1;
            data = bc_data[c*XLEN +: XLEN];
         end
      end
   end

endmodule

// File: rtl/lsb_queue_v2.sv
// In-order load/store buffer: holds memory ops in program order, snoops
// broadcasts for operands and issues the head entry through a registered FSM.
module lsb_queue_v2
   import lsb_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ROB_W  = LSB_ROB_W,
   parameter int NUM_BC = 2,
   parameter int XLEN   = LSB_XLEN
) (
   input  logic                    clk_in,
   input  logic                    rst_n_in,
   input  logic                    rdy_in,
   input  logic                    flush,
   input  logic                    dec_rdy,
   input  logic [3:0]              dec_type,
   input  logic [XLEN-1:0]         dec_data_j,
   input  logic [XLEN-1:0]         dec_data_k,
   input  logic                    dec_pending_j,
   input  logic                    dec_pending_k,
   input  logic [ROB_W-1:0]        dec_dependency_j,
   input  logic [ROB_W-1:0]        dec_dependency_k,
   input  logic [ROB_W-1:0]        dec_rob_id,
   input  logic [XLEN-1:0]         dec_imm,
   output logic                    dec_full,
   output logic                    dec_almost_full,
   input  logic [NUM_BC-1:0]       bc_en,
   input  logic [NUM_BC*ROB_W-1:0] bc_rob_id,
   input  logic [NUM_BC*XLEN-1:0]  bc_data,
   input  logic                    commit_en,
   input  logic [ROB_W-1:0]        commit_rob_id,
   output logic                    mc_en,
   output logic [XLEN-1:0]         mc_addr,
   output logic [3:0]              mc_type,
   output logic [XLEN-1:0]         mc_write_data,
   input  logic                    mc_rdy,
   input  logic [XLEN-1:0]         mc_read_data,
   output logic                    out_en,
   output logic [ROB_W-1:0]        out_rob_id,
   output logic [XLEN-1:0]         out_data
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   lsb_entry_t       ent_q [DEPTH];
   lsb_entry_t       ent_d [DEPTH];
   logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d, survivors;
   lsb_state_e       state_q, state_d;
   logic             mc_en_q, mc_en_d, out_en_q, out_en_d;
   logic [XLEN-1:0]  mc_addr_q, mc_addr_d, mc_wdata_q, mc_wdata_d, out_data_q, out_data_d;
   logic [3:0]       mc_type_q, mc_type_d;
   logic [ROB_W-1:0] out_rob_id_q, out_rob_id_d;

   logic [DEPTH-1:0] hit_j, hit_k;
   logic [XLEN-1:0]  bc_val_j [DEPTH];
   logic [XLEN-1:0]  bc_val_k [DEPTH];
   logic             ins_hit_j, ins_hit_k;
   logic [XLEN-1:0]  ins_val_j, ins_val_k;
   logic             head_ready, retire, can_insert;

   for (genvar i = 0; i < DEPTH; i++) begin : g_wake
      lsb_bc_match #(.NUM_BC(NUM_BC), .ROB_W(ROB_W), .XLEN(XLEN)) u_match_j (
         .tag(ent_q[i].dep_j), .bc_en(bc_en), .bc_rob_id(bc_rob_id), .bc_data(bc_data),
         .hit(hit_j[i]), .data(bc_val_j[i]));
      lsb_bc_match #(.NUM_BC(NUM_BC), .ROB_W(ROB_W), .XLEN(XLEN)) u_match_k (
         .tag(ent_q[i].dep_k), .bc_en(bc_en), .bc_rob_id(bc_rob_id), .bc_data(bc_data),
         .hit(hit_k[i]), .data(bc_val_k[i]));
   end

   lsb_bc_match #(.NUM_BC(NUM_BC), .ROB_W(ROB_W), .XLEN(XLEN)) u_ins_j (
      .tag(dec_dependency_j), .bc_en(bc_en), .bc_rob_id(bc_rob_id), .bc_data(bc_data),
      .hit(ins_hit_j), .data(ins_val_j));
   lsb_bc_match #(.NUM_BC(NUM_BC), .ROB_W(ROB_W), .XLEN(XLEN)) u_ins_k (
      .tag(dec_dependency_k), .bc_en(bc_en), .bc_rob_id(bc_rob_id), .bc_data(bc_data),
      .hit(ins_hit_k), .data(ins_val_k));

   assign head_ready = ent_q[head_q].valid && !ent_q[head_q].pending_j && !ent_q[head_q].pending_k
                       && (!ent_q[head_q].op_type[STORE_BIT] || ent_q[head_q].committed);
   assign retire     = (state_q == REQ) && mc_rdy;
   assign can_insert = dec_rdy && !flush && ((count_q != CW'(DEPTH)) || retire);

   always_comb begin
      ent_d        = ent_q;
      head_d       = head_q;
      tail_d       = tail_q;
      count_d      = count_q;
      state_d      = state_q;
      mc_en_d      = mc_en_q;
      mc_addr_d    = mc_addr_q;
      mc_type_d    = mc_type_q;
      mc_wdata_d   = mc_wdata_q;
      out_en_d     = out_en_q;
      out_rob_id_d = out_rob_id_q;
      out_data_d   = out_data_q;
      survivors    = '0;
      if (rdy_in) begin
         out_en_d = 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            if (ent_q[i].valid && ent_q[i].pending_j && hit_j[i]) begin
               ent_d[i].data_j    = bc_val_j[i];
               ent_d[i].pending_j = 1'b0;
            end
            if (ent_q[i].valid && ent_q[i].pending_k && hit_k[i]) begin
               ent_d[i].data_k    = bc_val_k[i];
               ent_d[i].pending_k = 1'b0;
            end
            if (ent_q[i].valid && commit_en && (ent_q[i].rob_id == commit_rob_id))
               ent_d[i].committed = 1'b1;
         end

         // Retirement and issue are exclusive so a freed head is re-examined next cycle.
         if (retire) begin
            ent_d[head_q].valid = 1'b0;
            head_d  = head_q + 1'b1;
            state_d = IDLE;
            mc_en_d = 1'b0;
            if (!ent_q[head_q].op_type[STORE_BIT] && !ent_q[head_q].killed && !flush) begin
               out_en_d     = 1'b1;
               out_rob_id_d = ent_q[head_q].rob_id;
               out_data_d   = extend_load(ent_q[head_q].op_type, mc_read_data);
            end
         end else if (state_q == IDLE && head_ready && !ent_q[head_q].killed
                      && (!flush || ent_q[head_q].committed)) begin
            state_d    = REQ;
            mc_en_d    = 1'b1;
            mc_addr_d  = ent_q[head_q].data_j + ent_q[head_q].imm;
            mc_type_d  = ent_q[head_q].op_type;
            mc_wdata_d = ent_q[head_q].data_k;
         end

         // An in-flight load cannot be recalled, so its entry stays valid but marked killed.
         if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (ent_d[i].valid && !ent_d[i].committed) begin
                  if (state_q == REQ && !retire && PW'(i) == head_q)
                     ent_d[i].killed = 1'b1;
                  else
                     ent_d[i].valid = 1'b0;
               end
            end
            for (int i = 0; i < DEPTH; i++)
               survivors = survivors + CW'(ent_d[i].valid);
            count_d = survivors;
            tail_d  = head_d + PW'(survivors);
         end else begin
            if (can_insert) begin
               ent_d[tail_q].valid     = 1'b1;
               ent_d[tail_q].committed = 1'b0;
               ent_d[tail_q].killed    = 1'b0;
               ent_d[tail_q].op_type   = dec_type;
               ent_d[tail_q].pending_j = dec_pending_j && !ins_hit_j;
               ent_d[tail_q].pending_k = dec_pending_k && !ins_hit_k;
               ent_d[tail_q].data_j    = (dec_pending_j && ins_hit_j) ? ins_val_j : dec_data_j;
               ent_d[tail_q].data_k    = (dec_pending_k && ins_hit_k) ? ins_val_k : dec_data_k;
               ent_d[tail_q].dep_j     = dec_dependency_j;
               ent_d[tail_q].dep_k     = dec_dependency_k;
               ent_d[tail_q].rob_id    = dec_rob_id;
               ent_d[tail_q].imm       = dec_imm;
               tail_d = tail_q + 1'b1;
            end
            count_d = count_q + CW'(can_insert) - CW'(retire);
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         state_q      <= IDLE;
         mc_en_q      <= 1'b0;
         mc_addr_q    <= '0;
         mc_type_q    <= '0;
         mc_wdata_q   <= '0;
         out_en_q     <= 1'b0;
         out_rob_id_q <= '0;
         out_data_q   <= '0;
      end else begin
         ent_q        <= ent_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         state_q      <= state_d;
         mc_en_q      <= mc_en_d;
         mc_addr_q    <= mc_addr_d;
         mc_type_q    <= mc_type_d;
         mc_wdata_q   <= mc_wdata_d;
         out_en_q     <= out_en_d;
         out_rob_id_q <= out_rob_id_d;
         out_data_q   <= out_data_d;
      end
   end

   assign dec_full        = (count_q == CW'(DEPTH));
   assign dec_almost_full = (count_q >= CW'(DEPTH - 1));
   assign mc_en           = mc_en_q;
   assign mc_addr         = mc_addr_q;
   assign mc_type         = mc_type_q;
   assign mc_write_data   = mc_wdata_q;
   assign out_en          = out_en_q;
   assign out_rob_id      = out_rob_id_q;
   assign out_data        = out_data_q;

endmodule
